ahb_apb3_bridge_nx: RTL and testbench

AHB_APB3_BRIDGE_NX -- requirements
Module: ahb_apb3_bridge_nx

---
 rtl/ahb_apb3_bridge_pkg.sv | 45 ++++
 rtl/ahb_apb3_bridge_nx_apb_slot_mux.sv | 32 +++
 rtl/ahb_apb3_bridge_nx.sv | 196 +++++++++++++++++++
 tb/tb_ahb_apb3_bridge_nx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb3_bridge_pkg.sv
// Shared types and encodings for the AHB-Lite to APB3 bridge.
// Holds the bridge state enum, HTRANS/HRESP codes and small helpers.
package ahb_apb3_bridge_pkg;

  // state     | meaning
  // ST_IDLE   | no transfer in flight, zero-wait OKAY to the AHB side
  // ST_LATCH  | address/control latched, write data captured this cycle
  // ST_SETUP  | APB setup phase, PSEL[slot]=1, PENABLE=0
  // ST_ACCESS | APB access phase, waiting for PREADY[slot]
  // ST_ERR1   | first ERROR response cycle, HREADYOUT=0
  // ST_ERR2   | second ERROR response cycle, HREADYOUT=1, may accept
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Slot index width; a single-slot bridge still carries a 1-bit index.
  function automatic int slot_width(input int nslots);
    return (nslots > 1) ? $clog2(nslots) : 1;
  endfunction

  // NONSEQ and SEQ start real transfers; IDLE and BUSY never do.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic active;
    active = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/ahb_apb3_bridge_nx_apb_slot_mux.sv
// Per-slot APB3 return selector: picks PRDATA/PREADY/PSLVERR of the
// currently addressed slot; all other slots are ignored.
module apb_slot_mux
  import ahb_apb3_bridge_pkg::*;
#(
  parameter int NSLOTS = 16,
  parameter int SLOT_W = slot_width(NSLOTS)
) (
  input  logic [SLOT_W-1:0]      slot_i,
  input  logic [32*NSLOTS-1:0]   prdata_i,
  input  logic [NSLOTS-1:0]      pready_i,
  input  logic [NSLOTS-1:0]      pslverr_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o
);

  // Combinational slot select.
  always_comb begin
    prdata_o  = '0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (int'(slot_i) == k) begin
        prdata_o  = prdata_i[32*k +: 32];
        pready_o  = pready_i[k];
        pslverr_o = pslverr_i[k];
      end
    end
  end

endmodule

// File: rtl/ahb_apb3_bridge_nx.sv
// AHB-Lite slave to APB3 master bridge with up to 16 one-hot APB slots.
// Optional PREADY timeout: define BRIDGE_PTIMEOUT_EN to abort an ACCESS
// phase with an ERROR response after TIMEOUT wait cycles.
//
// state     | meaning
// ST_IDLE   | ready for a transfer, zero-wait OKAY
// ST_LATCH  | address latched, HWDATA captured on writes
// ST_SETUP  | APB setup phase
// ST_ACCESS | APB access phase, waits for PREADY[slot]
// ST_ERR1   | ERROR response, first cycle (HREADYOUT=0)
// ST_ERR2   | ERROR response, second cycle (HREADYOUT=1)
module ahb_apb3_bridge_nx
  import ahb_apb3_bridge_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int NSLOTS   = 16,
  parameter int SLOT_LSB = 20,
  parameter int TIMEOUT  = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [ADDR_W-1:0]     HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [NSLOTS-1:0]     PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic [32*NSLOTS-1:0]  PRDATA,
  input  logic [NSLOTS-1:0]     PREADY,
  input  logic [NSLOTS-1:0]     PSLVERR
);

  localparam int SLOT_W = slot_width(NSLOTS);

  generate
    if (ADDR_W < 12 || ADDR_W > 32 || NSLOTS < 1 || NSLOTS > 16 ||
        (NSLOTS & (NSLOTS - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255 ||
        (NSLOTS > 1 && SLOT_LSB + $clog2(NSLOTS) > ADDR_W)) begin : g_bad_param
      $error("ahb_apb3_bridge_nx: illegal parameter combination");
    end
  endgenerate

  bridge_state_e         state_q;
  logic [SLOT_W-1:0]     slot_q;
  logic [ADDR_W-1:0]     paddr_q;
  logic [NSLOTS-1:0]     psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [31:0]           pwdata_q;
  logic [31:0]           hrdata_q;
  logic                  hreadyout_q;
  logic [1:0]            hresp_q;

`ifdef BRIDGE_PTIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0]            tmo_cnt_q;
`endif

  logic [SLOT_W-1:0]     haddr_slot;
  logic [NSLOTS-1:0]     slot_onehot;
  logic                  accept;
  logic [31:0]           sel_prdata;
  logic                  sel_pready;
  logic                  sel_pslverr;

  generate
    if (NSLOTS > 1) begin : g_slot
      assign haddr_slot = HADDR[SLOT_LSB +: SLOT_W];
    end else begin : g_noslot
      assign haddr_slot = '0;
    end
  endgenerate

  assign accept = HSEL & HREADY & htrans_active(HTRANS);

  // One-hot PSEL pattern for the latched slot.
  always_comb begin
    slot_onehot = '0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (int'(slot_q) == k) slot_onehot[k] = 1'b1;
    end
  end

  apb_slot_mux #(
    .NSLOTS (NSLOTS),
    .SLOT_W (SLOT_W)
  ) u_slot_mux (
    .slot_i    (slot_q),
    .prdata_i  (PRDATA),
    .pready_i  (PREADY),
    .pslverr_i (PSLVERR),
    .prdata_o  (sel_prdata),
    .pready_o  (sel_pready),
    .pslverr_o (sel_pslverr)
  );

  // Bridge FSM; every output is a register updated on the state transition.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
`ifdef BRIDGE_PTIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR2: begin
          hresp_q <= HRESP_OKAY;
          if (accept) begin
            state_q     <= ST_LATCH;
            hreadyout_q <= 1'b0;
            paddr_q     <= HADDR;
            pwrite_q    <= HWRITE;
            slot_q      <= haddr_slot;
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
          end
        end
        ST_LATCH: begin
          state_q <= ST_SETUP;
          psel_q  <= slot_onehot;
          if (pwrite_q) pwdata_q <= HWDATA;
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
`ifdef BRIDGE_PTIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ST_ACCESS: begin
          if (sel_pready) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (sel_pslverr) begin
              state_q <= ST_ERR1;
              hresp_q <= HRESP_ERROR;
            end else begin
              state_q     <= ST_IDLE;
              hreadyout_q <= 1'b1;
              if (!pwrite_q) hrdata_q <= sel_prdata;
            end
          end
`ifdef BRIDGE_PTIMEOUT_EN
          else if (tmo_cnt_q + 8'd1 == TIMEOUT_CNT) begin
            state_q   <= ST_ERR1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            hresp_q   <= HRESP_ERROR;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          psel_q      <= '0;
          penable_q   <= 1'b0;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb3_bridge_nx.sv
// Directed self-checking bench for ahb_apb3_bridge_nx.
module tb_ahb_apb3_bridge_nx;

  localparam int ADDR_W   = 24;
  localparam int NSLOTS   = 16;
  localparam int SLOT_LSB = 20;
  localparam int TIMEOUT  = 16;

  logic                 hclk = 1'b0;
  logic                 hresetn = 1'b0;
  logic                 hsel = 1'b0;
  logic [ADDR_W-1:0]    haddr = '0;
  logic [1:0]           htrans = 2'b00;
  logic                 hwrite = 1'b0;
  logic [31:0]          hwdata = '0;
  logic                 hready = 1'b1;
  logic [31:0]          hrdata;
  logic                 hreadyout;
  logic [1:0]           hresp;
  logic [ADDR_W-1:0]    paddr;
  logic [NSLOTS-1:0]    psel;
  logic                 penable;
  logic                 pwrite;
  logic [31:0]          pwdata;
  logic [32*NSLOTS-1:0] prdata = '0;
  logic [NSLOTS-1:0]    pready = '1;
  logic [NSLOTS-1:0]    pslverr = '0;

  int n_checks = 0;
  int n_errors = 0;

  int                r_waits, r_pen, r_err_cycles, r_setup_idx;
  logic [NSLOTS-1:0] r_psel, r_err_psel;
  logic [31:0]       r_pwdata;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite, r_done;
  logic [1:0]        r_hresp;

  always #5 hclk = ~hclk;

  ahb_apb3_bridge_nx #(
    .ADDR_W   (ADDR_W),
    .NSLOTS   (NSLOTS),
    .SLOT_LSB (SLOT_LSB),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .HCLK      (hclk),
    .HRESETN   (hresetn),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HRDATA    (hrdata),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .PADDR     (paddr),
    .PSEL      (psel),
    .PENABLE   (penable),
    .PWRITE    (pwrite),
    .PWDATA    (pwdata),
    .PRDATA    (prdata),
    .PREADY    (pready),
    .PSLVERR   (pslverr)
  );

  // Drives one NONSEQ transfer and acts as the APB slave for 'slot':
  // PREADY stays low for 'ready_after' ACCESS cycles. Unselected slots
  // present PREADY=1 / PSLVERR=1 so any leakage shows up. Observations
  // are left in the r_* variables; called right after a sample point.
  task automatic xfer(input logic [ADDR_W-1:0] addr, input logic wr,
                      input logic [31:0] wdata, input int slot,
                      input int ready_after, input logic err, input int limit);
    int acc = 0;
    int n = 0;
    r_waits = 0; r_pen = 0; r_err_cycles = 0; r_setup_idx = 0;
    r_psel = '0; r_err_psel = '1; r_pwdata = '0; r_paddr = '0;
    r_pwrite = 1'b0; r_hresp = 2'b11; r_done = 1'b0;
    pready = '1; pready[slot] = 1'b0;
    pslverr = '1; pslverr[slot] = err;
    hsel = 1'b1; haddr = addr; hwrite = wr; htrans = 2'b10; hready = 1'b1;
    while (n < limit && !r_done) begin
      @(posedge hclk); #1;
      n++;
      if (n == 1) begin
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hwdata = wdata;
      end
      if (hresp == 2'b01) begin
        if (r_err_cycles == 0) r_err_psel = psel;
        r_err_cycles++;
      end
      if (hreadyout) begin
        r_done = 1'b1;
        r_hresp = hresp;
      end else begin
        r_waits++;
        if (psel != '0 && !penable && r_setup_idx == 0) begin
          r_setup_idx = n; r_psel = psel; r_pwdata = pwdata;
          r_paddr = paddr; r_pwrite = pwrite;
        end
        if (penable) begin
          r_pen++;
          acc++;
        end
        pready[slot] = penable && (acc > ready_after);
      end
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    n_checks++; if (hreadyout !== 1'b1) begin n_errors++; $display("FAIL rst_hreadyout: got %b expected 1", hreadyout); end
    n_checks++; if (hresp !== 2'b00) begin n_errors++; $display("FAIL rst_hresp: got %b expected 00", hresp); end
    n_checks++; if (psel !== 16'h0000) begin n_errors++; $display("FAIL rst_psel: got %h expected 0000", psel); end
    n_checks++; if (penable !== 1'b0) begin n_errors++; $display("FAIL rst_penable: got %b expected 0", penable); end
    n_checks++; if (pwrite !== 1'b0) begin n_errors++; $display("FAIL rst_pwrite: got %b expected 0", pwrite); end
    n_checks++; if (paddr !== 24'h0) begin n_errors++; $display("FAIL rst_paddr: got %h expected 000000", paddr); end
    n_checks++; if (pwdata !== 32'h0) begin n_errors++; $display("FAIL rst_pwdata: got %h expected 00000000", pwdata); end
    n_checks++; if (hrdata !== 32'h0) begin n_errors++; $display("FAIL rst_hrdata: got %h expected 00000000", hrdata); end
    @(posedge hclk); #2;
    hresetn = 1'b1;
    @(posedge hclk); #1;
  endtask

  task automatic test_idle_busy();
    logic [1:0] codes [3];
    logic       rdy [3];
    codes[0] = 2'b00; rdy[0] = 1'b1;
    codes[1] = 2'b01; rdy[1] = 1'b1;
    codes[2] = 2'b10; rdy[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hsel = 1'b1; haddr = 24'h300000; hwrite = 1'b1; htrans = codes[i]; hready = rdy[i];
      repeat (2) begin
        @(posedge hclk); #1;
        n_checks++; if (hreadyout !== 1'b1) begin n_errors++; $display("FAIL idle_hreadyout[%0d]: got %b expected 1", i, hreadyout); end
        n_checks++; if (hresp !== 2'b00) begin n_errors++; $display("FAIL idle_hresp[%0d]: got %b expected 00", i, hresp); end
        n_checks++; if (psel !== 16'h0000) begin n_errors++; $display("FAIL idle_psel[%0d]: got %h expected 0000", i, psel); end
      end
    end
    hsel = 1'b0; htrans = 2'b00; hready = 1'b1; haddr = '0; hwrite = 1'b0;
    @(posedge hclk); #1;
  endtask

  task automatic test_write_ok();
    xfer(24'h300010, 1'b1, 32'hCAFEF00D, 3, 0, 1'b0, 20);
    n_checks++; if (r_done !== 1'b1) begin n_errors++; $display("FAIL wr_done: got %b expected 1", r_done); end
    n_checks++; if (r_waits != 3) begin n_errors++; $display("FAIL wr_waits: got %0d expected 3", r_waits); end
    n_checks++; if (r_setup_idx != 2) begin n_errors++; $display("FAIL wr_setup_idx: got %0d expected 2", r_setup_idx); end
    n_checks++; if (r_psel !== 16'h0008) begin n_errors++; $display("FAIL wr_psel: got %h expected 0008", r_psel); end
    n_checks++; if (r_pwdata !== 32'hCAFEF00D) begin n_errors++; $display("FAIL wr_pwdata: got %h expected cafef00d", r_pwdata); end
    n_checks++; if (r_paddr !== 24'h300010) begin n_errors++; $display("FAIL wr_paddr: got %h expected 300010", r_paddr); end
    n_checks++; if (r_pwrite !== 1'b1) begin n_errors++; $display("FAIL wr_pwrite: got %b expected 1", r_pwrite); end
    n_checks++; if (r_pen != 1) begin n_errors++; $display("FAIL wr_penable_cycles: got %0d expected 1", r_pen); end
    n_checks++; if (r_hresp !== 2'b00) begin n_errors++; $display("FAIL wr_hresp: got %b expected 00", r_hresp); end
    n_checks++; if (hrdata !== 32'h0) begin n_errors++; $display("FAIL wr_hrdata_hold: got %h expected 00000000", hrdata); end
  endtask

  task automatic test_read_wait();
    for (int k = 0; k < NSLOTS; k++) prdata[32*k +: 32] = 32'hA0000000 | k;
    prdata[32*10 +: 32] = 32'h12345678;
    xfer(24'hA00004, 1'b0, 32'h0, 10, 5, 1'b0, 40);
    n_checks++; if (r_done !== 1'b1) begin n_errors++; $display("FAIL rd_done: got %b expected 1", r_done); end
    n_checks++; if (r_waits != 8) begin n_errors++; $display("FAIL rd_waits: got %0d expected 8", r_waits); end
    n_checks++; if (r_pen != 6) begin n_errors++; $display("FAIL rd_penable_cycles: got %0d expected 6", r_pen); end
    n_checks++; if (hrdata !== 32'h12345678) begin n_errors++; $display("FAIL rd_hrdata: got %h expected 12345678", hrdata); end
    n_checks++; if (r_psel !== 16'h0400) begin n_errors++; $display("FAIL rd_psel: got %h expected 0400", r_psel); end
    n_checks++; if (r_pwrite !== 1'b0) begin n_errors++; $display("FAIL rd_pwrite: got %b expected 0", r_pwrite); end
    n_checks++; if (pwdata !== 32'hCAFEF00D) begin n_errors++; $display("FAIL rd_pwdata_hold: got %h expected cafef00d", pwdata); end
    n_checks++; if (paddr !== 24'hA00004) begin n_errors++; $display("FAIL rd_paddr_hold: got %h expected a00004", paddr); end
    n_checks++; if (r_hresp !== 2'b00) begin n_errors++; $display("FAIL rd_hresp: got %b expected 00", r_hresp); end
  endtask

  task automatic test_slverr();
    xfer(24'h200008, 1'b1, 32'h55AA55AA, 2, 0, 1'b1, 20);
    n_checks++; if (r_done !== 1'b1) begin n_errors++; $display("FAIL err_done: got %b expected 1", r_done); end
    n_checks++; if (r_waits != 4) begin n_errors++; $display("FAIL err_waits: got %0d expected 4", r_waits); end
    n_checks++; if (r_err_cycles != 2) begin n_errors++; $display("FAIL err_cycles: got %0d expected 2", r_err_cycles); end
    n_checks++; if (r_err_psel !== 16'h0000) begin n_errors++; $display("FAIL err1_psel: got %h expected 0000", r_err_psel); end
    n_checks++; if (r_hresp !== 2'b01) begin n_errors++; $display("FAIL err2_hresp: got %b expected 01", r_hresp); end
    n_checks++; if (hrdata !== 32'h12345678) begin n_errors++; $display("FAIL err_hrdata_hold: got %h expected 12345678", hrdata); end
    @(posedge hclk); #1;
    n_checks++; if (hresp !== 2'b00) begin n_errors++; $display("FAIL err_after_hresp: got %b expected 00", hresp); end
    n_checks++; if (hreadyout !== 1'b1) begin n_errors++; $display("FAIL err_after_hreadyout: got %b expected 1", hreadyout); end
  endtask

  task automatic test_back_to_back();
    prdata[32*0  +: 32] = 32'h0BADBEEF;
    prdata[32*15 +: 32] = 32'h87654321;
    xfer(24'h000010, 1'b0, 32'h0, 0, 0, 1'b0, 20);
    n_checks++; if (r_waits != 3) begin n_errors++; $display("FAIL b2b_first_waits: got %0d expected 3", r_waits); end
    n_checks++; if (hrdata !== 32'h0BADBEEF) begin n_errors++; $display("FAIL b2b_first_hrdata: got %h expected 0badbeef", hrdata); end
    xfer(24'hF0000C, 1'b0, 32'h0, 15, 0, 1'b0, 20);
    n_checks++; if (r_setup_idx != 2) begin n_errors++; $display("FAIL b2b_second_setup_idx: got %0d expected 2", r_setup_idx); end
    n_checks++; if (r_waits != 3) begin n_errors++; $display("FAIL b2b_second_waits: got %0d expected 3", r_waits); end
    n_checks++; if (r_psel !== 16'h8000) begin n_errors++; $display("FAIL b2b_second_psel: got %h expected 8000", r_psel); end
    n_checks++; if (hrdata !== 32'h87654321) begin n_errors++; $display("FAIL b2b_second_hrdata: got %h expected 87654321", hrdata); end
  endtask

  task automatic test_timeout();
`ifdef BRIDGE_PTIMEOUT_EN
    xfer(24'h500000, 1'b0, 32'h0, 5, 100000, 1'b0, 40);
    n_checks++; if (r_done !== 1'b1) begin n_errors++; $display("FAIL tmo_done: got %b expected 1", r_done); end
    n_checks++; if (r_pen != 16) begin n_errors++; $display("FAIL tmo_access_cycles: got %0d expected 16", r_pen); end
    n_checks++; if (r_waits != 19) begin n_errors++; $display("FAIL tmo_waits: got %0d expected 19", r_waits); end
    n_checks++; if (r_err_cycles != 2) begin n_errors++; $display("FAIL tmo_err_cycles: got %0d expected 2", r_err_cycles); end
    n_checks++; if (r_err_psel !== 16'h0000) begin n_errors++; $display("FAIL tmo_err1_psel: got %h expected 0000", r_err_psel); end
    n_checks++; if (r_hresp !== 2'b01) begin n_errors++; $display("FAIL tmo_hresp: got %b expected 01", r_hresp); end
`else
    xfer(24'h500000, 1'b0, 32'h0, 5, 100000, 1'b0, 300);
    n_checks++; if (r_done !== 1'b0) begin n_errors++; $display("FAIL notmo_done: got %b expected 0", r_done); end
    n_checks++; if (r_pen != 298) begin n_errors++; $display("FAIL notmo_access_cycles: got %0d expected 298", r_pen); end
    n_checks++; if (psel !== 16'h0020) begin n_errors++; $display("FAIL notmo_psel: got %h expected 0020", psel); end
    n_checks++; if (penable !== 1'b1) begin n_errors++; $display("FAIL notmo_penable: got %b expected 1", penable); end
    n_checks++; if (hreadyout !== 1'b0) begin n_errors++; $display("FAIL notmo_hreadyout: got %b expected 0", hreadyout); end
    #2 hresetn = 1'b0;
    @(posedge hclk); #2;
    hresetn = 1'b1;
    @(posedge hclk); #1;
`endif
  endtask

  task automatic test_reset_mid();
    xfer(24'h700040, 1'b1, 32'hDEADBEEF, 7, 100000, 1'b0, 3);
    n_checks++; if (penable !== 1'b1) begin n_errors++; $display("FAIL rmid_in_access: got %b expected 1", penable); end
    #2 hresetn = 1'b0;
    #1;
    n_checks++; if (psel !== 16'h0000) begin n_errors++; $display("FAIL rmid_psel: got %h expected 0000", psel); end
    n_checks++; if (penable !== 1'b0) begin n_errors++; $display("FAIL rmid_penable: got %b expected 0", penable); end
    n_checks++; if (hreadyout !== 1'b1) begin n_errors++; $display("FAIL rmid_hreadyout: got %b expected 1", hreadyout); end
    n_checks++; if (hresp !== 2'b00) begin n_errors++; $display("FAIL rmid_hresp: got %b expected 00", hresp); end
    n_checks++; if (paddr !== 24'h0) begin n_errors++; $display("FAIL rmid_paddr: got %h expected 000000", paddr); end
    n_checks++; if (pwdata !== 32'h0) begin n_errors++; $display("FAIL rmid_pwdata: got %h expected 00000000", pwdata); end
    n_checks++; if (hrdata !== 32'h0) begin n_errors++; $display("FAIL rmid_hrdata: got %h expected 00000000", hrdata); end
    @(posedge hclk); #2;
    hresetn = 1'b1;
    xfer(24'h100020, 1'b1, 32'h13579BDF, 1, 0, 1'b0, 20);
    n_checks++; if (r_done !== 1'b1) begin n_errors++; $display("FAIL rpost_done: got %b expected 1", r_done); end
    n_checks++; if (r_hresp !== 2'b00) begin n_errors++; $display("FAIL rpost_hresp: got %b expected 00", r_hresp); end
    n_checks++; if (r_waits != 3) begin n_errors++; $display("FAIL rpost_waits: got %0d expected 3", r_waits); end
    n_checks++; if (r_psel !== 16'h0002) begin n_errors++; $display("FAIL rpost_psel: got %h expected 0002", r_psel); end
    n_checks++; if (r_pwdata !== 32'h13579BDF) begin n_errors++; $display("FAIL rpost_pwdata: got %h expected 13579bdf", r_pwdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_busy();
    test_write_ok();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
